// File: rtl/ahbl_bus_mux_defines.sv
// Shared definitions for the AHB-Lite bus mux: HTRANS encoding and arbiter limits.
package ahbl_bus_mux_defines;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam int ARB_MAX_MASTERS = 8;

endpackage

// File: rtl/ahbl_bus_arbiter_rr_pick.sv
// rr_pick: combinational rotate-find-first. Looks at requesters starting one
// slot after cur_idx, wrapping modulo N, and never returns cur_idx itself.
module rr_pick
    import ahbl_bus_mux_defines::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] cur_idx,
    output logic             found,
    output logic [IDX_W-1:0] next_idx
);

    logic [IDX_W-1:0] cand_idx [1:N-1];
    logic [N-1:1]     hit;

    // Candidate index at each rotation offset; one extra bit absorbs the wrap
    // so non-power-of-two N folds back to 0 instead of reaching unused codes.
    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_off
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, cur_idx} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                         : sum[IDX_W-1:0];
            assign hit[gi]      = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        found    = 1'b0;
        next_idx = cur_idx;
        for (int k = N - 1; k >= 1; k--) begin
            if (hit[k]) begin
                found    = 1'b1;
                next_idx = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/ahbl_bus_arbiter.sv
// ahbl_bus_arbiter: round-robin address-phase arbiter for the AHB-Lite bus mux.
// Grants move only on accepted transfers, are held through SEQ/BUSY beats and
// park on the last owner when nobody else asks.
// Optional feature: define ARB_LOCK_EN to hold the grant while the owner's
// HMASTLOCK_in is high.
module ahbl_bus_arbiter
    import ahbl_bus_mux_defines::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [NUM_MASTERS-1:0][1:0] HTRANS_in,
    input  logic [NUM_MASTERS-1:0]      HMASTLOCK_in,
    input  logic                        HREADY,
    output logic [NUM_MASTERS-1:0]      ARB_SEL,
    output logic [NUM_MASTERS-1:0]      ARB_SEL_PREV,
    output logic [IDX_W-1:0]            HMASTER
);

    logic [IDX_W-1:0]       hmaster_reg, hmaster_next;
    logic [NUM_MASTERS-1:0] sel_prev_reg, sel_prev_next;
    logic [NUM_MASTERS-1:0] req;
    logic [1:0]             owner_trans;
    logic                   lock_hold;
    logic                   hold;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

    // Request vector and one-hot grant decode of the owner index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign req[gi]     = (HTRANS_in[gi] != HTRANS_IDLE);
            assign ARB_SEL[gi] = (hmaster_reg == IDX_W'(gi));
        end
    endgenerate

    assign owner_trans  = HTRANS_in[hmaster_reg];
    assign HMASTER      = hmaster_reg;
    assign ARB_SEL_PREV = sel_prev_reg;

`ifdef ARB_LOCK_EN
    assign lock_hold = HMASTLOCK_in[hmaster_reg];
`else
    // Port kept for a uniform interface; the lock request has no effect here.
    logic unused_hmastlock;
    assign unused_hmastlock = ^HMASTLOCK_in;
    assign lock_hold        = 1'b0;
`endif

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .cur_idx  (hmaster_reg),
        .found    (pick_found),
        .next_idx (pick_idx)
    );

    // Next owner (hold on burst/lock, else rotate or park) and data-phase owner.
    always_comb begin
        hold          = (owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY) || lock_hold;
        hmaster_next  = hmaster_reg;
        sel_prev_next = '0;
        if (!hold && pick_found) begin
            hmaster_next = pick_idx;
        end
        if ((owner_trans == HTRANS_NONSEQ) || (owner_trans == HTRANS_SEQ)) begin
            sel_prev_next = ARB_SEL;
        end
    end

    // Grant state advances only on accepted transfers; wait states freeze it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hmaster_reg  <= '0;
            sel_prev_reg <= '0;
        end else if (HREADY) begin
            hmaster_reg  <= hmaster_next;
            sel_prev_reg <= sel_prev_next;
        end
    end

endmodule

// File: tb/tb_ahbl_bus_arbiter.sv
// Testbench for ahbl_bus_arbiter (3 masters, exercising the non-power-of-two wrap).
// A behavioural model tracks owner / data-phase owner as integers and is
// compared on every falling edge; directed steps add literal expectations.
module tb_ahbl_bus_arbiter;

    localparam int N = 3;
    localparam logic [1:0] I  = 2'b00;
    localparam logic [1:0] B  = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [N-1:0][1:0] htrans;
    logic [N-1:0]      hmastlock;
    logic              hready;
    logic [N-1:0]      arb_sel;
    logic [N-1:0]      arb_sel_prev;
    logic [1:0]        hmaster;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    int m_owner;
    int m_prev;

    ahbl_bus_arbiter #(.NUM_MASTERS(N)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HTRANS_in    (htrans),
        .HMASTLOCK_in (hmastlock),
        .HREADY       (hready),
        .ARB_SEL      (arb_sel),
        .ARB_SEL_PREV (arb_sel_prev),
        .HMASTER      (hmaster)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: owner index and data-phase owner (-1 = none).
    always @(posedge HCLK or negedge HRESETn) begin : model
        int  t;
        int  nxt;
        bit  held;
        bit  locked;
        if (!HRESETn) begin
            m_owner <= 0;
            m_prev  <= -1;
        end else if (hready) begin
            t      = int'(htrans[m_owner]);
            locked = 1'b0;
`ifdef ARB_LOCK_EN
            locked = hmastlock[m_owner];
`endif
            held = (t == 1) || (t == 3) || locked;
            nxt  = m_owner;
            if (!held) begin
                for (int k = N - 1; k >= 1; k--) begin
                    if (htrans[(m_owner + k) % N] != I) nxt = (m_owner + k) % N;
                end
            end
            m_prev  <= ((t == 2) || (t == 3)) ? m_owner : -1;
            m_owner <= nxt;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("model_sel",  int'(arb_sel),      1 << m_owner);
            chk("model_prev", int'(arb_sel_prev), (m_prev < 0) ? 0 : (1 << m_prev));
            chk("model_hm",   int'(hmaster),      m_owner);
        end
    end

    task automatic step(input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] t2,
                        input logic [N-1:0] lk, input logic rdy);
        htrans[0] = t0;
        htrans[1] = t1;
        htrans[2] = t2;
        hmastlock = lk;
        hready    = rdy;
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic expect3(input string name, input int sel, input int prev, input int hm);
        chk({name, "_sel"},  int'(arb_sel),      sel);
        chk({name, "_prev"}, int'(arb_sel_prev), prev);
        chk({name, "_hm"},   int'(hmaster),      hm);
        $display("step %-10s sel=%b prev=%b hm=%0d", name, arb_sel, arb_sel_prev, hmaster);
    endtask

    initial begin
        HRESETn   = 1'b0;
        htrans    = '0;
        hmastlock = '0;
        hready    = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        chk_en  = 1'b1;
        expect3("reset", 'b001, 'b000, 0);

        // Parked master 0 issues NONSEQ with zero arbitration latency.
        step(NS, I, I, '0, 1'b1);   expect3("park", 'b001, 'b001, 0);
        // Both request; rotation hands over to master 1.
        step(NS, NS, I, '0, 1'b1);  expect3("handover", 'b010, 'b001, 1);
        // INCR4 on master 1; master 0 waits through the SEQ beats.
        step(I, NS, I, '0, 1'b1);   expect3("b_nseq", 'b010, 'b010, 1);
        step(NS, SQ, I, '0, 1'b1);  expect3("b_seq1", 'b010, 'b010, 1);
        step(NS, SQ, I, '0, 1'b1);  expect3("b_seq2", 'b010, 'b010, 1);
        step(NS, SQ, I, '0, 1'b1);  expect3("b_seq3", 'b010, 'b010, 1);
        step(NS, I, I, '0, 1'b1);   expect3("b_done", 'b001, 'b000, 0);
        // Wait states freeze everything during a handover.
        step(NS, NS, I, '0, 1'b0);  expect3("wait1", 'b001, 'b000, 0);
        step(NS, NS, I, '0, 1'b0);  expect3("wait2", 'b001, 'b000, 0);
        step(NS, NS, I, '0, 1'b0);  expect3("wait3", 'b001, 'b000, 0);
        step(NS, NS, I, '0, 1'b1);  expect3("wait_go", 'b010, 'b001, 1);
        step(NS, NS, I, '0, 1'b1);  expect3("back0", 'b001, 'b010, 0);
        // Locked owner 0 goes IDLE while master 1 requests.
`ifdef ARB_LOCK_EN
        step(I, NS, I, 3'b001, 1'b1); expect3("lock1", 'b001, 'b000, 0);
        step(I, NS, I, 3'b001, 1'b1); expect3("lock2", 'b001, 'b000, 0);
        step(I, NS, I, 3'b000, 1'b1); expect3("unlock", 'b010, 'b000, 1);
`else
        step(I, NS, I, 3'b001, 1'b1); expect3("lock1", 'b010, 'b000, 1);
        step(I, NS, I, 3'b001, 1'b1); expect3("lock2", 'b010, 'b010, 1);
        step(I, NS, I, 3'b000, 1'b1); expect3("unlock", 'b010, 'b010, 1);
`endif
        // Rotation order from owner 1 picks 2 before 0, then wraps 2 -> 0.
        step(NS, I, NS, '0, 1'b1);  expect3("rot12", 'b100, 'b000, 2);
        step(NS, NS, NS, '0, 1'b1); expect3("wrap20", 'b001, 'b100, 0);
        step(NS, NS, I, '0, 1'b1);  expect3("to1", 'b010, 'b001, 1);
        // Asynchronous reset in the middle of a cycle.
        htrans[0] = I; htrans[1] = NS; htrans[2] = I;
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1 expect3("async_rst", 'b001, 'b000, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < N; m++) begin
                htrans[m]    = ($urandom_range(0, 9) < 4) ? I : 2'($urandom_range(1, 3));
                hmastlock[m] = ($urandom_range(0, 3) == 0);
            end
            hready = ($urandom_range(0, 3) != 0);
            @(posedge HCLK);
            @(negedge HCLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
